// File: rtl/fifo_push_arbiter_pkg.sv
// Shared types and width helpers for the round-robin FIFO push arbiter.
package fifo_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

   // Width of an index into NREQ producers (at least one bit).
   function automatic int unsigned owner_w(input int unsigned nreq);
      return (nreq > 1) ? $clog2(nreq) : 1;
   endfunction

   // Width of a counter that must be able to hold the value BURST.
   function automatic int unsigned burst_w(input int unsigned burst);
      return $clog2(burst + 1);
   endfunction

endpackage

// File: rtl/fifo_push_arbiter_if.sv
// Producer-side request/data bundle plus the FIFO write port seen by the arbiter.
interface fifo_push_arbiter_if #(
   parameter int unsigned NREQ  = 4,
   parameter int unsigned WIDTH = 4
);
   import fifo_arb_pkg::*;

   localparam int unsigned OWNER_W = owner_w(NREQ);

   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] data;
   logic [NREQ-1:0]       ack;
   logic                  fifo_push_req;
   logic [WIDTH-1:0]      fifo_data_in;
   logic                  fifo_push_ack;
   logic                  fifo_full;
   logic [OWNER_W-1:0]    owner;
   logic                  owner_vld;

   // Arbiter side
   modport master (
      input  req, data, fifo_push_ack, fifo_full,
      output ack, fifo_push_req, fifo_data_in, owner, owner_vld
   );

   // Producers and FIFO side
   modport slave (
      output req, data, fifo_push_ack, fifo_full,
      input  ack, fifo_push_req, fifo_data_in, owner, owner_vld
   );

endinterface

// File: rtl/fifo_push_arbiter_rr_pick.sv
// Round-robin picker: first asserted req scanning last+1, last+2, ... with wrap.
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int unsigned NREQ    = 4,
   parameter int unsigned OWNER_W = owner_w(NREQ)
) (
   input  logic [NREQ-1:0]    req,
   input  logic [OWNER_W-1:0] last,
   output logic [OWNER_W-1:0] idx,
   output logic               any
);

   logic [OWNER_W-1:0] scan;

   // The last position visited is 'last' itself, so a lone requester re-wins.
   always_comb begin
      idx  = '0;
      any  = 1'b0;
      scan = '0;
      for (int unsigned i = 1; i <= NREQ; i++) begin
         scan = OWNER_W'((32'(last) + i) % NREQ);
         if (!any && req[scan]) begin
            any = 1'b1;
            idx = scan;
         end
      end
   end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Shares one FIFO write port among NREQ producers, holding each grant for up to
// BURST accepted pushes before rotating round-robin.
module fifo_push_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int unsigned NREQ  = 4,
   parameter int unsigned WIDTH = 4,
   parameter int unsigned BURST = 4
) (
   input logic                 clk,
   input logic                 resetn,
   fifo_push_arbiter_if.master bus
);

   localparam int unsigned OWNER_W = owner_w(NREQ);
   localparam int unsigned BURST_W = burst_w(BURST);

   arb_state_e         state_q, state_d;
   logic [OWNER_W-1:0] owner_q, owner_d;
   logic [OWNER_W-1:0] last_q, last_d;
   logic [BURST_W-1:0] burst_q, burst_d;

   logic [OWNER_W-1:0] pick_from;
   logic [OWNER_W-1:0] pick_idx;
   logic               pick_any;
   logic               granted;
   logic               owner_req;
   logic               xfer;
   logic               expire;
   logic               tenure_end;
   logic [BURST_W-1:0] burst_inc;
   logic [NREQ-1:0]    ack_vec;

   // One picker serves both IDLE entry (from last) and release (from owner).
   assign pick_from = (state_q == GRANT) ? owner_q : last_q;

   rr_pick #(
      .NREQ    (NREQ),
      .OWNER_W (OWNER_W)
   ) u_pick (
      .req  (bus.req),
      .last (pick_from),
      .idx  (pick_idx),
      .any  (pick_any)
   );

   assign granted    = (state_q == GRANT);
   assign owner_req  = bus.req[owner_q];
   assign xfer       = granted && owner_req && bus.fifo_push_ack;
   assign burst_inc  = burst_q + BURST_W'(1);
   assign expire     = xfer && (burst_inc == BURST_W'(BURST));
   assign tenure_end = granted && (!owner_req || expire);

   // Next-state: stalls on full leave burst_q untouched.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      burst_d = burst_q;
      case (state_q)
         IDLE: begin
            if (pick_any) begin
               state_d = GRANT;
               owner_d = pick_idx;
               burst_d = '0;
            end
         end
         GRANT: begin
            if (tenure_end) begin
               last_d  = owner_q;
               burst_d = '0;
               if (pick_any) begin
                  owner_d = pick_idx;
               end else begin
                  state_d = IDLE;
               end
            end else if (xfer) begin
               burst_d = burst_inc;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         owner_q <= '0;
         last_q  <= OWNER_W'(NREQ - 1);
         burst_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         burst_q <= burst_d;
      end
   end

   always_comb begin
      ack_vec = '0;
      if (xfer) begin
         ack_vec[owner_q] = 1'b1;
      end
   end

   // Push side is combinational so FIFO back-pressure reaches the owner unchanged.
   assign bus.ack           = ack_vec;
   assign bus.fifo_push_req = granted && owner_req;
   assign bus.fifo_data_in  = granted ? WIDTH'(bus.data >> (32'(owner_q) * WIDTH)) : '0;
   assign bus.owner         = owner_q;
   assign bus.owner_vld     = granted;

`ifndef SYNTHESIS
   a_ack_onehot0 : assert property (@(posedge clk) disable iff (!resetn)
      $onehot0(bus.ack));
   a_ack_owner   : assert property (@(posedge clk) disable iff (!resetn)
      (bus.ack != '0) |-> (granted && (bus.ack == (NREQ'(1) << owner_q)) && ((bus.ack & bus.req) != '0)));
   a_push_vld    : assert property (@(posedge clk) disable iff (!resetn)
      bus.fifo_push_req |-> bus.owner_vld);
   a_burst_max   : assert property (@(posedge clk) disable iff (!resetn)
      burst_q <= BURST_W'(BURST));
   a_full_no_ack : assert property (@(posedge clk) disable iff (!resetn)
      bus.fifo_full |-> !bus.fifo_push_ack);
`endif

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Self-checking bench: directed cycle table, hand sequences and a randomized run
// against a cycle-level reference model with a 16-deep FIFO model.
module tb_fifo_push_arbiter;

   localparam int NREQ  = 4;
   localparam int WIDTH = 4;
   localparam int BURST = 4;
   localparam int DEPTH = 16;
   localparam int DW    = NREQ * WIDTH;
   localparam int BOUND = (NREQ - 1) * BURST;
   localparam int NTBL  = 14;
   localparam int NRAND = 3000;

   logic clk = 1'b0;
   logic resetn;
   always #5 clk = ~clk;

   fifo_push_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

   assign bus.fifo_push_ack = bus.fifo_push_req && !bus.fifo_full;

   fifo_push_arbiter #(
      .NREQ  (NREQ),
      .WIDTH (WIDTH),
      .BURST (BURST)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus.master)
   );

   typedef struct {
      logic [NREQ-1:0] req;
      logic            full;
      logic            vld;
      int              owner;
      logic [NREQ-1:0] ack;
   } vec_t;

   vec_t            tbl [NTBL];
   logic [WIDTH-1:0] word [NREQ];
   int              n_pass  = 0;
   int              n_total = 0;

   // Reference model and traffic state
   bit              m_g;
   int              m_owner, m_last, m_cnt;
   int              fifo_cnt;
   bit              active [NREQ];
   int              left [NREQ];
   int              wait_x [NREQ];
   logic [NREQ-1:0] r;
   logic            full, e_push, e_xfer;
   int              pop_pct;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   function automatic logic bit_at(input logic [NREQ-1:0] v, input int idx);
      return 1'(v >> idx);
   endfunction

   function automatic logic [DW-1:0] pack_words();
      logic [DW-1:0] d;
      d = '0;
      for (int i = 0; i < NREQ; i++) d = d | (DW'(word[i]) << (i * WIDTH));
      return d;
   endfunction

   function automatic int pick(input logic [NREQ-1:0] rv, input int from);
      for (int i = 1; i <= NREQ; i++) begin
         int k;
         k = (from + i) % NREQ;
         if (bit_at(rv, k)) return k;
      end
      return 0;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      bus.req = '0;
      bus.fifo_full = 1'b0;
      bus.data = pack_words();
      @(negedge clk);
      chk("rst_owner_vld", 32'(bus.owner_vld), 32'd0);
      chk("rst_owner", 32'(bus.owner), 32'd0);
      chk("rst_ack", 32'(bus.ack), 32'd0);
      chk("rst_push_req", 32'(bus.fifo_push_req), 32'd0);
      chk("rst_data_in", 32'(bus.fifo_data_in), 32'd0);
      @(posedge clk);
      #1 resetn = 1'b1;
   endtask

   task automatic drive_rand();
      logic [NREQ-1:0] rv;
      rv = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (!active[i] && $urandom_range(2) == 0) begin
            active[i] = 1'b1;
            word[i]   = WIDTH'($urandom);
            left[i]   = int'($urandom_range(6, 1));
         end
         if (active[i]) rv = rv | (NREQ'(1) << i);
      end
      bus.req       = rv;
      bus.data      = pack_words();
      bus.fifo_full = (fifo_cnt == DEPTH);
   endtask

   initial begin
      for (int i = 0; i < NREQ; i++) word[i] = WIDTH'(4'hA + i);
      do_reset();

      // Directed cycles: wrap-around from last=3, early drop, full stall, burst expiry.
      tbl[0]  = '{4'b0000, 1'b0, 1'b0, 0, 4'b0000};
      tbl[1]  = '{4'b1001, 1'b0, 1'b0, 0, 4'b0000};
      tbl[2]  = '{4'b1001, 1'b0, 1'b1, 0, 4'b0001};
      tbl[3]  = '{4'b1000, 1'b0, 1'b1, 0, 4'b0000};
      tbl[4]  = '{4'b1000, 1'b0, 1'b1, 3, 4'b1000};
      tbl[5]  = '{4'b1000, 1'b1, 1'b1, 3, 4'b0000};
      tbl[6]  = '{4'b1000, 1'b0, 1'b1, 3, 4'b1000};
      tbl[7]  = '{4'b1010, 1'b0, 1'b1, 3, 4'b1000};
      tbl[8]  = '{4'b1010, 1'b0, 1'b1, 3, 4'b1000};
      tbl[9]  = '{4'b1010, 1'b0, 1'b1, 1, 4'b0010};
      tbl[10] = '{4'b1000, 1'b0, 1'b1, 1, 4'b0000};
      tbl[11] = '{4'b1000, 1'b0, 1'b1, 3, 4'b1000};
      tbl[12] = '{4'b0000, 1'b0, 1'b1, 3, 4'b0000};
      tbl[13] = '{4'b0000, 1'b0, 1'b0, 0, 4'b0000};

      for (int i = 0; i < NTBL; i++) begin
         logic exp_push;
         bus.req       = tbl[i].req;
         bus.fifo_full = tbl[i].full;
         @(negedge clk);
         exp_push = tbl[i].vld && bit_at(tbl[i].req, tbl[i].owner) && 1'b1;
         chk($sformatf("tbl%0d_vld", i), 32'(bus.owner_vld), 32'(tbl[i].vld));
         if (tbl[i].vld) chk($sformatf("tbl%0d_owner", i), 32'(bus.owner), 32'(tbl[i].owner));
         chk($sformatf("tbl%0d_ack", i), 32'(bus.ack), 32'(tbl[i].ack));
         chk($sformatf("tbl%0d_push_req", i), 32'(bus.fifo_push_req), 32'(exp_push));
         chk($sformatf("tbl%0d_data_in", i), 32'(bus.fifo_data_in),
             tbl[i].vld ? 32'(word[tbl[i].owner]) : 32'd0);
         tick();
      end

      // Lone producer 2 with 6 words: re-wins at expiry with no bubble.
      do_reset();
      word[2] = 4'h1;
      bus.data = pack_words();
      bus.req = 4'b0100;
      @(negedge clk);
      chk("solo_idle_ack", 32'(bus.ack), 32'd0);
      tick();
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk($sformatf("solo_ack%0d", k), 32'(bus.ack), 32'b0100);
         chk($sformatf("solo_owner%0d", k), 32'(bus.owner), 32'd2);
         chk($sformatf("solo_data%0d", k), 32'(bus.fifo_data_in), 32'(k + 1));
         tick();
         if (k < 5) begin
            word[2] = WIDTH'(k + 2);
            bus.data = pack_words();
         end else begin
            bus.req = '0;
         end
      end
      @(negedge clk);
      chk("solo_done_ack", 32'(bus.ack), 32'd0);
      chk("solo_done_push", 32'(bus.fifo_push_req), 32'd0);
      tick();

      // Reset during owner 2's second push.
      do_reset();
      word[2] = 4'h5;
      bus.data = pack_words();
      bus.req = 4'b0100;
      @(negedge clk);
      chk("mrst_idle_vld", 32'(bus.owner_vld), 32'd0);
      tick();
      @(negedge clk);
      chk("mrst_first_ack", 32'(bus.ack), 32'b0100);
      tick();
      word[2] = 4'h6;
      bus.data = pack_words();
      @(negedge clk);
      chk("mrst_second_ack", 32'(bus.ack), 32'b0100);
      #1 resetn = 1'b0;
      #1;
      chk("mrst_ack", 32'(bus.ack), 32'd0);
      chk("mrst_vld", 32'(bus.owner_vld), 32'd0);
      chk("mrst_push_req", 32'(bus.fifo_push_req), 32'd0);
      chk("mrst_data_in", 32'(bus.fifo_data_in), 32'd0);
      @(posedge clk);
      #1 resetn = 1'b1;
      bus.req = 4'b0101;
      @(negedge clk);
      chk("mrst_after_vld", 32'(bus.owner_vld), 32'd0);
      tick();
      @(negedge clk);
      chk("mrst_win_owner", 32'(bus.owner), 32'd0);
      chk("mrst_win_ack", 32'(bus.ack), 32'b0001);
      tick();

      // Randomized traffic against the reference model.
      for (int i = 0; i < NREQ; i++) begin
         active[i] = 1'b0;
         left[i]   = 0;
         wait_x[i] = 0;
      end
      do_reset();
      m_g = 1'b0;
      m_owner = 0;
      m_last = NREQ - 1;
      m_cnt = 0;
      fifo_cnt = 0;
      drive_rand();
      for (int cyc = 0; cyc < NRAND; cyc++) begin
         r    = bus.req;
         full = bus.fifo_full;
         @(negedge clk);
         e_push = m_g && bit_at(r, m_owner);
         e_xfer = e_push && !full;
         chk("rnd_vld", 32'(bus.owner_vld), 32'(m_g));
         if (m_g) begin
            chk("rnd_owner", 32'(bus.owner), 32'(m_owner));
            chk("rnd_data_in", 32'(bus.fifo_data_in), 32'(word[m_owner]));
         end
         chk("rnd_ack", 32'(bus.ack), e_xfer ? 32'(NREQ'(1) << m_owner) : 32'd0);
         chk("rnd_push_req", 32'(bus.fifo_push_req), 32'(e_push));
         for (int i = 0; i < NREQ; i++) begin
            if (bit_at(bus.ack, i)) begin
               n_total++;
               if (wait_x[i] <= BOUND) n_pass++;
               else $display("FAIL fairness p%0d: waited %0d transfers, limit %0d", i, wait_x[i], BOUND);
               wait_x[i] = 0;
            end else if (!bit_at(r, i)) begin
               wait_x[i] = 0;
            end else if (bus.ack != '0) begin
               wait_x[i]++;
            end
         end
         @(posedge clk);
         pop_pct = ((cyc / 400) % 2 == 1) ? 35 : 85;
         if (fifo_cnt > 0 && int'($urandom_range(99)) < pop_pct) fifo_cnt--;
         if (e_xfer) begin
            fifo_cnt++;
            left[m_owner]--;
            if (left[m_owner] == 0 || $urandom_range(3) == 0) active[m_owner] = 1'b0;
            else word[m_owner] = WIDTH'($urandom);
         end
         if (!m_g) begin
            if (r != '0) begin
               m_g = 1'b1;
               m_owner = pick(r, m_last);
               m_cnt = 0;
            end
         end else begin
            if (e_xfer) m_cnt++;
            if (!bit_at(r, m_owner) || (e_xfer && m_cnt == BURST)) begin
               m_last = m_owner;
               m_cnt = 0;
               if (r != '0) m_owner = pick(r, m_owner);
               else m_g = 1'b0;
            end
         end
         #1;
         drive_rand();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/fifo_push_arbiter.md
# fifo_push_arbiter

Round-robin push-side arbiter that shares a single FIFO write port among NREQ producers. It sits directly in front of the FIFO: it selects one owner and muxes that owner's data onto the FIFO push interface. It holds the grant for up to BURST accepted pushes, then rotates. FIFO full back-pressure passes through to the owner unchanged.

## Interface
- NREQ, 4, number of producers (2..16)
- WIDTH, 4, data width; equals the FIFO WIDTH
- BURST, 4, maximum pushes per grant tenure (>=1)
- clk  in  1  clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- req  in  NREQ  per-producer push request; level, valid-style
- data  in  NREQ*WIDTH  producer i data at bits [i*WIDTH +: WIDTH]
- ack  out  NREQ  one-hot or zero; ack[i] means producer i's word was pushed this cycle
- fifo_push_req  out  1  to FIFO push_req
- fifo_data_in  out  WIDTH  to FIFO data_in
- fifo_push_ack  in  1  from FIFO push_ack (push_req && !full, combinational)
- fifo_full  in  1  from FIFO full
- owner  out  $clog2(NREQ)  current grant holder; valid only when owner_vld
- owner_vld  out  1  grant held (state GRANT)

## Operation
- States: IDLE, GRANT. Registers: state, owner, last (round-robin pointer), burst_cnt (width $clog2(BURST+1)).
- Pick: first asserted req scanning last+1, last+2, ... modulo NREQ, wrapping.
- IDLE: if |req, load owner=pick, burst_cnt=0, go to GRANT; else stay.
- GRANT, outputs:
  - fifo_push_req = req[owner]
  - fifo_data_in = data[owner]
  - ack[owner] = fifo_push_ack; all other ack bits 0.
- Transfer: a transfer occurs when ack[owner]=1. It increments burst_cnt.
- Release: occurs when req[owner]=0, or when a transfer makes burst_cnt reach BURST.
  - On release, set last=owner.
  - Re-arbitrate the same cycle using current req, with the scan starting at owner+1.
  - If any req is set, stay in GRANT with the new owner and burst_cnt=0. Otherwise go to IDLE.
- Burst expiry: if the owner is the only requester at expiry, it wins again with a fresh burst.
- FIFO full: fifo_push_ack=0, so no transfer, burst_cnt holds and the grant is held. The stall does not count toward BURST.
- Producer rule: once req[i] is asserted, req[i] and the data slice stay stable until ack[i].
- Outside IDLE/GRANT-owner: fifo_push_req=0 and fifo_data_in=0 in IDLE.

## Timing
- Reset values: state=IDLE, owner=0, owner_vld=0, last=NREQ-1 (so producer 0 wins first), burst_cnt=0, ack=0, fifo_push_req=0, fifo_data_in=0.
- Arbitration latency: req rising at cycle t in IDLE gives owner_vld at t+1. The first ack is at t+1 if the FIFO is not full.
- Throughput:
  - 1 push/cycle within a tenure.
  - Zero-bubble handover when release coincides with another pending req.
  - One idle cycle only when entering from IDLE.
- Simultaneous events:
  - Transfer plus burst expiry in the same cycle: the push completes, then the grant rotates at the next edge.
  - Owner drops req in the same cycle another raises req: that other producer is considered immediately.
- Reset mid-tenure: immediate return to IDLE; no ack on the reset cycle. Any partially presented word is not pushed.
- Assertions:
  - ack is onehot0.
  - ack[i] implies req[i] and owner==i.
  - fifo_push_req implies owner_vld.
  - burst_cnt<=BURST.
  - Fairness bound: a continuously requesting producer is acked within (NREQ-1)*BURST transfers plus full-stall cycles.

## Structure
- fifo_arb_pkg: state enum (IDLE, GRANT), and the localparam width helpers for owner and burst_cnt.
- Sub-module rr_pick (combinational): inputs req and last; outputs idx and any. It is reused for the IDLE and release paths.
- Top module: FSM, counters, and the data/ack mux. Target about 150-250 lines total.

## Test plan
- Single producer: req[2]=1 with 6 words, BURST=4, FIFO empty. Acks at t+1..t+4; owner 2 re-wins with a zero-bubble tenure; acks continue t+5..t+6. FIFO contents are in order.
- Contention: req=4'b1111 continuously, 16 words total. Grant order is 0,1,2,3, 4 acks each; each FIFO push equals the owner's data. The FIFO reaches full (ptr=16).
- Full stall: FIFO pre-filled to 15, owner 1 has 3 words. One ack, then ack=0 while full with owner 1 held and burst_cnt=1. After one FIFO pop, the next ack arrives the following cycle.
- Early drop: owner 0 drops req after 2 acks while req[3]=1. Owner becomes 3 at the next edge with no idle cycle; producer 0 gets no further ack.
- Wrap-around: last=3 (NREQ=4), req=4'b1001. Producer 0 wins, then producer 3.
- Reset mid-tenure: resetn low during owner 2's second push. On deassert, state=IDLE, owner_vld=0, ack=0, and producer 0 wins the next arbitration.
